// File: rtl/chacha20_stream_ctrl.sv
// Sequences one ChaCha20 block core across a multi-block message over valid/ready streams.
// Optional COUNTER_WRAP_ERR_EN: reject configurations whose block counter would wrap.
module chacha20_stream_ctrl #(
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [255:0]         cfg_key,
  input  logic [95:0]          cfg_nonce,
  input  logic [31:0]          cfg_counter,
  input  logic [BLK_CNT_W-1:0] cfg_blocks,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [511:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [511:0]         out_data,
  output logic                 msg_done,
  output logic                 busy,
  output logic                 err,
  output logic                 core_start,
  input  logic                 core_busy,
  input  logic                 core_done,
  output logic [255:0]         core_key,
  output logic [95:0]          core_nonce,
  output logic [31:0]          core_counter,
  output logic [511:0]         core_state,
  input  logic [511:0]         core_out
);

  typedef enum logic [2:0] {IDLE, WAIT_IN, START, WAIT_DONE, OUT, DRAIN} state_e;

  localparam logic [BLK_CNT_W-1:0] ONE_BLK = 1;

  state_e                state_q, state_d;
  logic                  live_q;
  logic                  zeroDone_q;
  logic [BLK_CNT_W-1:0]  remaining_q;
  logic [255:0]          coreKey_q;
  logic [95:0]           coreNonce_q;
  logic [31:0]           coreCounter_q;
  logic [511:0]          coreState_q;
  logic [511:0]          outData_q;

  logic cfgLoad, zeroDone, inTake, coreCapture, outAdvance, lastHandoff;

  // The core reports its own activity, but completion is taken from core_done alone.
  logic unusedCoreBusy;
  assign unusedCoreBusy = core_busy;

`ifdef COUNTER_WRAP_ERR_EN
  logic cfgReject, wrapErr, err_q;
  assign wrapErr = ({1'b0, cfg_counter} + 33'(cfg_blocks) - 33'd1) > 33'h0_FFFF_FFFF;
`endif

  always_comb begin
    state_d     = state_q;
    cfgLoad     = 1'b0;
    zeroDone    = 1'b0;
    inTake      = 1'b0;
    coreCapture = 1'b0;
    outAdvance  = 1'b0;
    lastHandoff = 1'b0;
`ifdef COUNTER_WRAP_ERR_EN
    cfgReject   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cfg_valid && live_q) begin
          if (cfg_blocks == '0) begin
            zeroDone = 1'b1;
          end
`ifdef COUNTER_WRAP_ERR_EN
          else if (wrapErr) begin
            cfgReject = 1'b1;
          end
`endif
          else begin
            cfgLoad = 1'b1;
            state_d = WAIT_IN;
          end
        end
      end
      WAIT_IN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (in_valid) begin
          inTake  = 1'b1;
          state_d = START;
        end
      end
      START: state_d = abort ? DRAIN : WAIT_DONE;
      WAIT_DONE: begin
        // A done arriving with the abort already retires the block, so nothing is left to drain.
        if (abort) begin
          state_d = core_done ? IDLE : DRAIN;
        end else if (core_done) begin
          coreCapture = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          outAdvance = 1'b1;
          if (remaining_q == ONE_BLK) begin
            lastHandoff = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = WAIT_IN;
          end
        end
      end
      DRAIN: begin
        if (core_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zeroDone_q    <= 1'b0;
      remaining_q   <= '0;
      coreKey_q     <= '0;
      coreNonce_q   <= '0;
      coreCounter_q <= '0;
      coreState_q   <= '0;
      outData_q     <= '0;
    end else begin
      zeroDone_q <= zeroDone;
      if (cfgLoad) begin
        coreKey_q     <= cfg_key;
        coreNonce_q   <= cfg_nonce;
        coreCounter_q <= cfg_counter;
        remaining_q   <= cfg_blocks;
      end
      if (inTake) coreState_q <= in_data;
      if (coreCapture) outData_q <= core_out;
      if (outAdvance) begin
        coreCounter_q <= coreCounter_q + 32'd1;
        remaining_q   <= remaining_q - ONE_BLK;
      end
    end
  end

`ifdef COUNTER_WRAP_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= cfgReject;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cfg_ready    = live_q && (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign in_ready     = (state_q == WAIT_IN);
  assign core_start   = (state_q == START);
  assign out_valid    = (state_q == OUT);
  assign out_data     = outData_q;
  assign msg_done     = zeroDone_q | lastHandoff;
  assign core_key     = coreKey_q;
  assign core_nonce   = coreNonce_q;
  assign core_counter = coreCounter_q;
  assign core_state   = coreState_q;

endmodule

// File: tb/tb_chacha20_stream_ctrl.sv
// Scoreboard bench for chacha20_stream_ctrl with a stand-in block core and random traffic.
// Honours COUNTER_WRAP_ERR_EN in the counter-wrap scenario.
module tb_chacha20_stream_ctrl;

  localparam int BLK_CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cfg_valid, cfg_ready;
  logic [255:0]         cfg_key;
  logic [95:0]          cfg_nonce;
  logic [31:0]          cfg_counter;
  logic [BLK_CNT_W-1:0] cfg_blocks;
  logic                 abort;
  logic                 in_valid, in_ready;
  logic [511:0]         in_data;
  logic                 out_valid, out_ready;
  logic [511:0]         out_data;
  logic                 msg_done, busy, err;
  logic                 core_start, core_busy, core_done;
  logic [255:0]         core_key;
  logic [95:0]          core_nonce;
  logic [31:0]          core_counter;
  logic [511:0]         core_state, core_out;

  chacha20_stream_ctrl #(.BLK_CNT_W(BLK_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key), .cfg_nonce(cfg_nonce),
    .cfg_counter(cfg_counter), .cfg_blocks(cfg_blocks), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .msg_done(msg_done), .busy(busy), .err(err),
    .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
    .core_key(core_key), .core_nonce(core_nonce), .core_counter(core_counter),
    .core_state(core_state), .core_out(core_out)
  );

  typedef struct {
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr;
    logic [511:0] blk;
  } startExp_t;

  typedef struct {
    logic [511:0] data;
    logic         last;
  } outExp_t;

  startExp_t startQ[$];
  outExp_t   outQ[$];
  int        errors = 0;
  int        checks = 0;
  int        doneCount = 0;
  logic      holdOut = 1'b0;

  always #5 clk = ~clk;

  // Stand-in keystream function: any fixed mix of key, nonce, counter and block will do.
  function automatic logic [511:0] coreFn(input logic [255:0] k, input logic [95:0] n,
                                          input logic [31:0] c, input logic [511:0] s);
    return s ^ {k, n, c, {4{c ^ 32'h61707865}}};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Stand-in core: latches its inputs on start, answers after 2..6 cycles. Driven
  // shortly after the rising edge so the controller samples it cleanly.
  initial begin
    int cnt;
    logic [511:0] pend;
    cnt = 0;
    pend = '0;
    core_done = 1'b0;
    core_busy = 1'b0;
    core_out  = '0;
    forever begin
      @(posedge clk);
      #3;
      core_done = 1'b0;
      if (!rst_n) begin
        cnt = 0;
        core_busy = 1'b0;
      end else if (core_start) begin
        cnt = $urandom_range(2, 6);
        pend = coreFn(core_key, core_nonce, core_counter, core_state);
        core_busy = 1'b1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_done = 1'b1;
          core_out  = pend;
          core_busy = 1'b0;
        end
      end
    end
  end

  // Downstream backpressure: random unless a scenario is holding it off.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = holdOut ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Every core start must carry the next expected key/nonce/counter/block.
  always @(negedge clk) begin
    startExp_t e;
    if (rst_n && core_start) begin
      if (startQ.size() == 0) begin
        checkOutput("unexpected core_start", core_start, 1'b0);
      end else begin
        e = startQ.pop_front();
        checkOutput("core_counter", core_counter, e.ctr);
        checkOutput("core_key", core_key, e.key);
        checkOutput("core_nonce", core_nonce, e.nonce);
        checkOutput("core_state", core_state, e.blk);
      end
    end
  end

  // Output monitor: each pending handshake is checked against the scoreboard.
  always @(negedge clk) begin
    outExp_t e;
    if (rst_n && msg_done) doneCount++;
    if (rst_n && out_valid && out_ready) begin
      if (outQ.size() == 0) begin
        checkOutput("unexpected out_valid", out_valid, 1'b0);
      end else begin
        e = outQ.pop_front();
        checkOutput("out_data", out_data, e.data);
        checkOutput("msg_done at handoff", msg_done, e.last);
      end
    end
  end

  task automatic sendCfg(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                         input logic [BLK_CNT_W-1:0] b);
    int t = 0;
    while (!cfg_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    checkOutput("cfg_ready wait", cfg_ready, 1'b1);
    cfg_key = k;
    cfg_nonce = n;
    cfg_counter = c;
    cfg_blocks = b;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic feedBlock(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                           input logic last, input logic pushOut);
    logic [511:0] blk;
    int t = 0;
    blk = rand512();
    startQ.push_back('{k, n, c, blk});
    if (pushOut) outQ.push_back('{coreFn(k, n, c, blk), last});
    in_data = blk;
    in_valid = 1'b1;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    checkOutput("in_ready wait", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int t = 0;
    while (!(outQ.size() == 0 && cfg_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    checkOutput("message drained", (outQ.size() == 0 && cfg_ready), 1'b1);
  endtask

  task automatic applyStimulus(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                               input logic [BLK_CNT_W-1:0] b);
    sendCfg(k, n, c, b);
    for (int i = 0; i < int'(b); i++) feedBlock(k, n, c + 32'(i), (i == int'(b) - 1), 1'b1);
    waitDrain();
  endtask

  task automatic holdCheck();
    int t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    checkOutput("hold first out_valid", out_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold out_valid", out_valid, 1'b1);
      checkOutput("hold out_data", out_data, (outQ.size() != 0) ? outQ[0].data : ~out_data);
      checkOutput("hold in_ready", in_ready, 1'b0);
      checkOutput("hold core_start", core_start, 1'b0);
    end
    holdOut = 1'b0;
    t = 0;
    while (!(out_valid && out_ready) && t < 100) begin
      @(negedge clk);
      t++;
    end
    checkOutput("release handshake", (out_valid && out_ready), 1'b1);
    @(negedge clk);
    checkOutput("in_ready after release", in_ready, 1'b1);
  endtask

  initial begin
    logic [255:0] key;
    logic [95:0]  nonce;
    int d0, t;
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_key = '0;
    cfg_nonce = '0;
    cfg_counter = '0;
    cfg_blocks = '0;
    abort = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);

    // Reset state: everything quiet, including cfg_ready.
    checkOutput("reset cfg_ready", cfg_ready, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset out_valid", out_valid, 1'b0);
    checkOutput("reset in_ready", in_ready, 1'b0);
    checkOutput("reset msg_done", msg_done, 1'b0);
    checkOutput("reset err", err, 1'b0);
    checkOutput("reset core_start", core_start, 1'b0);
    checkOutput("reset core_counter", core_counter, 32'd0);
    checkOutput("reset out_data", out_data, 512'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("cfg_ready after release", cfg_ready, 1'b1);

    // Known-answer message: counters 1,2,3, done on the third handoff.
    for (int b = 0; b < 32; b++) key[255 - 8*b -: 8] = 8'(b);
    nonce = 96'h000000090000004a00000000;
    d0 = doneCount;
    applyStimulus(key, nonce, 32'd1, 16'd3);
    checkOutput("msg_done count 3-block", doneCount - d0, 1);

    // Backpressure on the first output.
    holdOut = 1'b1;
    d0 = doneCount;
    fork
      applyStimulus(rand512()[255:0], rand512()[95:0], 32'd40, 16'd2);
      holdCheck();
    join
    checkOutput("msg_done count hold", doneCount - d0, 1);

    // Empty message: done pulse without touching the core.
    d0 = doneCount;
    sendCfg(key, nonce, 32'd5, 16'd0);
    checkOutput("zero-block msg_done", msg_done, 1'b1);
    checkOutput("zero-block cfg_ready", cfg_ready, 1'b1);
    @(negedge clk);
    checkOutput("zero-block msg_done width", msg_done, 1'b0);
    checkOutput("zero-block busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("msg_done count zero-block", doneCount - d0, 1);

    // Abort while the core is working: result is swallowed.
    d0 = doneCount;
    sendCfg(key, nonce, 32'd100, 16'd2);
    feedBlock(key, nonce, 32'd100, 1'b0, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort busy", busy, 1'b1);
    checkOutput("abort out_valid", out_valid, 1'b0);
    checkOutput("abort cfg_ready", cfg_ready, 1'b0);
    t = 0;
    while (!core_done && t < 50) begin
      @(negedge clk);
      t++;
    end
    checkOutput("abort core_done seen", core_done, 1'b1);
    checkOutput("drain cfg_ready at done", cfg_ready, 1'b0);
    @(negedge clk);
    checkOutput("idle after drain", cfg_ready, 1'b1);
    checkOutput("drain out_valid", out_valid, 1'b0);
    checkOutput("abort no msg_done", doneCount - d0, 0);

    // Counter at the top of its range.
    applyStimulus(key, nonce, 32'hFFFF_FFFF, 16'd1);
    d0 = doneCount;
`ifdef COUNTER_WRAP_ERR_EN
    sendCfg(key, nonce, 32'hFFFF_FFFF, 16'd2);
    checkOutput("wrap err pulse", err, 1'b1);
    checkOutput("wrap cfg_ready", cfg_ready, 1'b1);
    checkOutput("wrap busy", busy, 1'b0);
    @(negedge clk);
    checkOutput("wrap err width", err, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("wrap stays idle", busy, 1'b0);
    checkOutput("wrap no msg_done", doneCount - d0, 0);
`else
    applyStimulus(key, nonce, 32'hFFFF_FFFF, 16'd2);
    checkOutput("msg_done count wrap", doneCount - d0, 1);
`endif

    // Reset while an output is pending.
    holdOut = 1'b1;
    sendCfg(key, nonce, 32'd7, 16'd1);
    feedBlock(key, nonce, 32'd7, 1'b1, 1'b1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    checkOutput("pre-reset out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset out_valid", out_valid, 1'b0);
    checkOutput("mid-reset busy", busy, 1'b0);
    checkOutput("mid-reset core_start", core_start, 1'b0);
    outQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    holdOut = 1'b0;
    @(negedge clk);
    checkOutput("cfg_ready after mid reset", cfg_ready, 1'b1);
    d0 = doneCount;
    applyStimulus(rand512()[255:0], rand512()[95:0], 32'd9, 16'd1);
    checkOutput("msg_done count post-reset", doneCount - d0, 1);

    // Random messages.
    d0 = doneCount;
    for (int m = 0; m < 8; m++) begin
      applyStimulus(rand512()[255:0], rand512()[95:0], 32'($urandom_range(0, 32'hFFFF_0000)),
                    16'($urandom_range(1, 4)));
    end
    checkOutput("msg_done count random", doneCount - d0, 8);
    checkOutput("start queue empty", startQ.size(), 0);
    checkOutput("out queue empty", outQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
